// File: rtl/coef_bank_seq_pkg.sv
// Shared definitions for the biquad coefficient bank sequencer: fixed-point
// format, power-up default coefficients and the sequencer state encoding.
package coef_bank_seq_pkg;

   // Fixed-point format of the coefficients: two's complement, 14 fractional bits.
   localparam int FRAC  = 14;
   localparam int DEF_W = 25;

   // Default low-pass biquad section, indices 0..5 (b0 = 1.0 expressed via FRAC).
   localparam logic [DEF_W-1:0] DEF_C0 = DEF_W'(1 << FRAC);   // 1.0
   localparam logic [DEF_W-1:0] DEF_C1 = 25'h1FF828F;          // -1.96
   localparam logic [DEF_W-1:0] DEF_C2 = 25'h0003D79;          // 0.9605
   localparam logic [DEF_W-1:0] DEF_C3 = 25'h0000003;          // 0.000199
   localparam logic [DEF_W-1:0] DEF_C4 = 25'h0000007;          // 0.000398
   localparam logic [DEF_W-1:0] DEF_C5 = 25'h0000003;          // 0.000199

   // Sequencer states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Default value for a coefficient index within a section; indices past
   // the six defined defaults come up as zero.
   function automatic logic [DEF_W-1:0] default_coef(input int idx);
      case (idx)
         0:       return DEF_C0;
         1:       return DEF_C1;
         2:       return DEF_C2;
         3:       return DEF_C3;
         4:       return DEF_C4;
         5:       return DEF_C5;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/coef_regfile.sv
// Double-buffered coefficient storage: a shadow bank written one entry at a
// time by software and an active bank read by the sequencer. A single copy
// strobe transfers the whole shadow bank into the active bank in one edge.
module coef_regfile
   import coef_bank_seq_pkg::*;
#(
   parameter int WIDTH = 25,
   parameter int NCOEF = 6,
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             copy,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] shadow [DEPTH];
   logic [WIDTH-1:0] active [DEPTH];
   logic             wr_hit;

   // Reset value of a bank entry: every section gets the same default set,
   // widened or narrowed as a signed quantity to the coefficient width.
   function automatic logic [WIDTH-1:0] reset_value(input int entry);
      return WIDTH'($signed(default_coef(entry % NCOEF)));
   endfunction

   // Writes to addresses past the end of the bank are dropped.
   assign wr_hit = wr_en && (int'(wr_addr) < DEPTH);

   // Shadow bank: single-entry write port.
   // NOTE: both banks are reset because the filter must run with known
   // coefficients straight out of reset; this is a small register bank, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) shadow[i] <= reset_value(i);
      end else if (wr_hit) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         shadow[wr_addr] <= wr_data;
      end
   end

   // Active bank: whole-bank copy from the shadow bank on the copy strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) active[i] <= reset_value(i);
      end else if (copy) begin
         for (int i = 0; i < DEPTH; i++) active[i] <= shadow[i];
      end
   end

   assign rd_data = (int'(rd_addr) < DEPTH) ? active[rd_addr] : '0;

endmodule

// File: rtl/coef_bank_seq.sv
// Coefficient bank sequencer: on start, streams every coefficient of every
// biquad section from the active bank to a downstream MAC with a valid/ready
// handshake. Software updates go to a shadow bank and are committed to the
// active bank only between sweeps, so a sweep never mixes old and new sets.
module coef_bank_seq
   import coef_bank_seq_pkg::*;
#(
   parameter  int WIDTH = 25,
   parameter  int NCOEF = 6,
   parameter  int NSEC  = 2,
   localparam int DEPTH = NSEC * NCOEF,
   localparam int SW    = (NSEC  > 1) ? $clog2(NSEC)  : 1,
   localparam int IW    = (NCOEF > 1) ? $clog2(NCOEF) : 1,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             coef_ready,
   output logic             coef_valid,
   output logic [WIDTH-1:0] coef_data,
   output logic [SW-1:0]    coef_sec,
   output logic [IW-1:0]    coef_idx,
   output logic             coef_last,
   output logic             busy,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit,
   output logic             commit_pending,
   output logic             overrun
);

   state_t        state;
   logic [SW-1:0] sec;
   logic [IW-1:0] idx;
   logic [AW-1:0] rd_addr;
   logic          handshake;
   logic          sec_end;
   logic          sweep_done;
   logic          copy;
   logic          wr_ok;

   assign handshake  = coef_valid && coef_ready;
   assign sec_end    = (idx == IW'(NCOEF - 1));
   assign coef_last  = coef_valid && sec_end && (sec == SW'(NSEC - 1));
   assign sweep_done = handshake && coef_last;

   // The bank is only swapped while no sweep is reading it: either idle, or
   // on the very edge that retires the last coefficient.
   assign copy  = commit_pending && ((state == ST_IDLE) || sweep_done);

   // Once a commit is queued the shadow bank is frozen until it is copied.
   assign wr_ok = wr_en && !commit_pending;

   assign rd_addr  = AW'(int'(sec) * NCOEF + int'(idx));
   assign coef_sec = sec;
   assign coef_idx = idx;

   // Sweep sequencer: state, section/index counters and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sec        <= '0;
         idx        <= '0;
         coef_valid <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= busy && start;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_RUN;
                  sec        <= '0;
                  idx        <= '0;
                  coef_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_RUN: begin
               if (handshake) begin
                  if (coef_last) begin
                     state      <= ST_IDLE;
                     sec        <= '0;
                     idx        <= '0;
                     coef_valid <= 1'b0;
                     busy       <= 1'b0;
                  end else if (sec_end) begin
                     idx <= '0;
                     sec <= sec + SW'(1);
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               coef_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // Commit bookkeeping: set on request, cleared by the copy itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_pending <= 1'b0;
      end else if (copy) begin
         commit_pending <= 1'b0;
      end else if (commit) begin
         commit_pending <= 1'b1;
      end
   end

   coef_regfile #(
      .WIDTH (WIDTH),
      .NCOEF (NCOEF),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .copy    (copy),
      .rd_addr (rd_addr),
      .rd_data (coef_data)
   );

endmodule

// File: tb/tb_coef_bank_seq.sv
// Self-checking bench for coef_bank_seq: a table-driven first sweep, hand
// sequences for stall/commit/overrun/reset corner cases, then randomized
// traffic, all compared against a sweep-position reference model.
`timescale 1ns/1ps
module tb_coef_bank_seq;

   localparam int WIDTH = 25;
   localparam int NCOEF = 6;
   localparam int NSEC  = 2;
   localparam int DEPTH = NSEC * NCOEF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              coef_ready;
   logic              wr_en;
   logic [3:0]        wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              commit;
   logic              coef_valid;
   logic [WIDTH-1:0]  coef_data;
   logic [0:0]        coef_sec;
   logic [2:0]        coef_idx;
   logic              coef_last;
   logic              busy;
   logic              commit_pending;
   logic              overrun;

   always #5 clk = ~clk;

   coef_bank_seq #(.WIDTH(WIDTH), .NCOEF(NCOEF), .NSEC(NSEC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .coef_ready     (coef_ready),
      .coef_valid     (coef_valid),
      .coef_data      (coef_data),
      .coef_sec       (coef_sec),
      .coef_idx       (coef_idx),
      .coef_last      (coef_last),
      .busy           (busy),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit         (commit),
      .commit_pending (commit_pending),
      .overrun        (overrun)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (sweep position based) ----------------
   logic [WIDTH-1:0] defaults [NCOEF];
   logic [WIDTH-1:0] m_shadow [DEPTH];
   logic [WIDTH-1:0] m_active [DEPTH];
   bit               m_busy, m_pending, m_overrun;
   int               m_pos;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_shadow[i] = defaults[i % NCOEF];
         m_active[i] = defaults[i % NCOEF];
      end
      m_busy = 0; m_pending = 0; m_overrun = 0; m_pos = 0;
   endtask

   // Effect of one rising edge given the inputs currently applied.
   task automatic model_edge();
      bit hs, done, cp, acc;
      hs   = m_busy && coef_ready;
      done = hs && (m_pos == DEPTH - 1);
      cp   = m_pending && (!m_busy || done);
      acc  = !m_busy && start;
      m_overrun = m_busy && start;
      if (cp) for (int i = 0; i < DEPTH; i++) m_active[i] = m_shadow[i];
      if (wr_en && int'(wr_addr) < DEPTH && !m_pending) m_shadow[wr_addr] = wr_data;
      if (cp) m_pending = 0;
      else if (commit) m_pending = 1;
      if (acc) begin m_busy = 1; m_pos = 0; end
      else if (done) begin m_busy = 0; m_pos = 0; end
      else if (hs) m_pos++;
   endtask

   task automatic compare_model();
      check("mdl_valid",   coef_valid,     m_busy);
      check("mdl_data",    coef_data,      m_active[m_pos]);
      check("mdl_sec",     coef_sec,       m_pos / NCOEF);
      check("mdl_idx",     coef_idx,       m_pos % NCOEF);
      check("mdl_last",    coef_last,      m_busy && m_pos == DEPTH - 1);
      check("mdl_busy",    busy,           m_busy);
      check("mdl_pending", commit_pending, m_pending);
      check("mdl_overrun", overrun,        m_overrun);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   // Run the current sweep to completion with ready high, bounded.
   task automatic finish_sweep();
      coef_ready = 1'b1;
      for (int n = 0; n < 40 && busy; n++) tick();
      check("sweep_end_busy", busy, 0);
   endtask

   // ---------------- table for the first full sweep ----------------
   typedef struct {
      bit               ready;
      bit               valid;
      logic [WIDTH-1:0] data;
      int               sec;
      int               idx;
      bit               last;
      bit               busy;
   } vec_t;
   vec_t vecs [DEPTH + 1];

   logic [WIDTH-1:0] exp_bank [DEPTH];
   int               valid_cycles, overrun_pulses;

   initial begin
      defaults[0] = 25'h0004000; defaults[1] = 25'h1FF828F; defaults[2] = 25'h0003D79;
      defaults[3] = 25'h0000003; defaults[4] = 25'h0000007; defaults[5] = 25'h0000003;
      for (int k = 0; k < DEPTH; k++)
         vecs[k] = '{1'b1, 1'b1, defaults[k % NCOEF], k / NCOEF, k % NCOEF, k == DEPTH - 1, 1'b1};
      vecs[DEPTH] = '{1'b1, 1'b0, defaults[0], 0, 0, 1'b0, 1'b0};

      // ---- reset ----
      rst_n = 1'b0; start = 0; coef_ready = 0; wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0;
      #12;
      check("rst_valid",   coef_valid, 0);
      check("rst_last",    coef_last, 0);
      check("rst_busy",    busy, 0);
      check("rst_pending", commit_pending, 0);
      check("rst_overrun", overrun, 0);
      check("rst_sec",     coef_sec, 0);
      check("rst_idx",     coef_idx, 0);
      check("rst_data",    coef_data, 25'h0004000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();

      // ---- full sweep with ready high, table driven ----
      start = 1; coef_ready = 1; tick(); start = 0;
      for (int k = 0; k <= DEPTH; k++) begin
         coef_ready = vecs[k].ready;
         check($sformatf("tbl_valid[%0d]", k), coef_valid, vecs[k].valid);
         check($sformatf("tbl_data[%0d]", k),  coef_data,  vecs[k].data);
         check($sformatf("tbl_sec[%0d]", k),   coef_sec,   vecs[k].sec);
         check($sformatf("tbl_idx[%0d]", k),   coef_idx,   vecs[k].idx);
         check($sformatf("tbl_last[%0d]", k),  coef_last,  vecs[k].last);
         check($sformatf("tbl_busy[%0d]", k),  busy,       vecs[k].busy);
         if (k < DEPTH) tick();
      end

      // ---- stall: ready low for three cycles at idx 2 ----
      start = 1; tick(); start = 0;
      coef_ready = 1; tick(); tick();
      coef_ready = 0;
      for (int n = 0; n < 3; n++) begin
         check("stall_data", coef_data, 25'h0003D79);
         check("stall_idx",  coef_idx, 2);
         tick();
      end
      check("stall_after_data", coef_data, 25'h0003D79);
      check("stall_after_idx",  coef_idx, 2);
      finish_sweep();

      // ---- write addr 7 + commit mid-sweep ----
      start = 1; tick(); start = 0;
      coef_ready = 1; tick(); tick();
      wr_en = 1; wr_addr = 4'd7; wr_data = 25'h0001000; commit = 1; tick();
      wr_en = 0; commit = 0;
      check("mid_pending_set", commit_pending, 1);
      for (int n = 0; n < 4; n++) tick();
      check("mid_old_sec", coef_sec, 1);
      check("mid_old_idx", coef_idx, 1);
      check("mid_old_data", coef_data, 25'h1FF828F);
      for (int n = 0; n < 4; n++) tick();
      check("mid_last", coef_last, 1);
      check("mid_pending_hold", commit_pending, 1);
      tick();
      check("mid_pending_clr", commit_pending, 0);
      check("mid_busy_clr", busy, 0);
      start = 1; tick(); start = 0;
      for (int n = 0; n < 7; n++) tick();
      check("mid_new_data", coef_data, 25'h0001000);
      finish_sweep();

      // ---- start during busy: one overrun pulse, length unchanged ----
      start = 1; coef_ready = 1; tick(); start = 0;
      valid_cycles = 0; overrun_pulses = 0;
      for (int n = 0; n < 40 && busy; n++) begin
         valid_cycles++;
         start = (n == 3);
         tick();
         if (overrun) overrun_pulses++;
      end
      start = 0;
      check("ovr_len", valid_cycles, DEPTH);
      check("ovr_pulses", overrun_pulses, 1);

      // ---- out-of-range write: bank unchanged after a commit ----
      wr_en = 1; wr_addr = 4'd12; wr_data = 25'h1ABCDE; commit = 1; tick();
      wr_en = 0; commit = 0;
      tick();
      check("oor_pending_clr", commit_pending, 0);
      for (int i = 0; i < DEPTH; i++) exp_bank[i] = defaults[i % NCOEF];
      exp_bank[7] = 25'h0001000;
      start = 1; tick(); start = 0;
      for (int k = 0; k < DEPTH; k++) begin
         check($sformatf("oor_data[%0d]", k), coef_data, exp_bank[k]);
         tick();
      end
      check("oor_busy_end", busy, 0);

      // ---- write addr 0, commit, then start on the copy edge ----
      wr_en = 1; wr_addr = 4'd0; wr_data = 25'h0002000; tick();
      wr_en = 0; commit = 1; tick();
      commit = 0;
      check("cs_pending", commit_pending, 1);
      start = 1; tick(); start = 0;
      check("cs_first_data", coef_data, 25'h0002000);
      check("cs_valid", coef_valid, 1);
      check("cs_pending_clr", commit_pending, 0);
      finish_sweep();

      // ---- reset at sweep cycle 5 with a commit pending ----
      start = 1; tick(); start = 0;
      wr_en = 1; wr_addr = 4'd3; wr_data = 25'h0055555; commit = 1; tick();
      wr_en = 0; commit = 0;
      tick(); tick(); tick();
      check("rr_pos", coef_idx, 4);
      check("rr_pending", commit_pending, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rr_valid",   coef_valid, 0);
      check("rr_last",    coef_last, 0);
      check("rr_busy",    busy, 0);
      check("rr_pending0", commit_pending, 0);
      check("rr_overrun", overrun, 0);
      check("rr_sec",     coef_sec, 0);
      check("rr_idx",     coef_idx, 0);
      check("rr_data",    coef_data, 25'h0004000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      start = 1; tick(); start = 0;
      for (int k = 0; k < DEPTH; k++) begin
         check($sformatf("rr_act[%0d]", k), coef_data, defaults[k % NCOEF]);
         tick();
      end
      commit = 1; tick(); commit = 0; tick();
      start = 1; tick(); start = 0;
      for (int k = 0; k < DEPTH; k++) begin
         check($sformatf("rr_shd[%0d]", k), coef_data, defaults[k % NCOEF]);
         tick();
      end

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 600; n++) begin
         start      = ($urandom % 8) == 0;
         coef_ready = ($urandom % 4) != 0;
         wr_en      = ($urandom % 3) == 0;
         wr_addr    = 4'($urandom % 16);
         wr_data    = WIDTH'($urandom);
         commit     = ($urandom % 10) == 0;
         tick();
      end
      start = 0; wr_en = 0; commit = 0;
      finish_sweep();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
